// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse receiver assembling 3-byte packets into the ps2_mouse word
//
// Receive-only: never drives the PS/2 lines.
// Ports:
//   clk        system clock (clk_sys)
//   reset_n    asynchronous active-low reset
//   ps2_clk    PS/2 clock line (asynchronous to clk)
//   ps2_data   PS/2 data line (asynchronous to clk)
//   ps2_mouse  {toggle, Y, X, byte0}; toggle flips once per accepted packet
//   frame_err  one-cycle pulse per rejected frame (bad parity or stop bit)
module ps2_mouse_rx #(
    parameter int          FILT    = 8,
    parameter logic [15:0] TIMEOUT = 16'd6000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic        frame_err
);

    localparam logic [3:0] FILT_LAST = 4'(FILT - 1);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_SHIFT   = 1'b1;

    logic [1:0]  clk_sync;
    logic [1:0]  dat_sync;
    logic        clk_f;
    logic        dat_f;
    logic        clk_f_d;
    logic [3:0]  clk_cnt;
    logic [3:0]  dat_cnt;
    logic        fall;

    logic [0:0]  state;
    logic [3:0]  bc;
    logic [1:0]  bi;
    logic [7:0]  shreg;
    logic        par;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] tcnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Each counter tracks how many consecutive synchronised samples have
    // disagreed with the filtered level; any agreeing sample restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_f   <= 1'b1;
            dat_f   <= 1'b1;
            clk_f_d <= 1'b1;
            clk_cnt <= 4'd0;
            dat_cnt <= 4'd0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_sync[1] == clk_f) begin
                clk_cnt <= 4'd0;
            end else if (clk_cnt == FILT_LAST) begin
                clk_f   <= clk_sync[1];
                clk_cnt <= 4'd0;
            end else begin
                clk_cnt <= clk_cnt + 4'd1;
            end
            if (dat_sync[1] == dat_f) begin
                dat_cnt <= 4'd0;
            end else if (dat_cnt == FILT_LAST) begin
                dat_f   <= dat_sync[1];
                dat_cnt <= 4'd0;
            end else begin
                dat_cnt <= dat_cnt + 4'd1;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // A falling edge takes priority over the timeout, so an edge arriving
    // in the expiry cycle is still decoded and the counter restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bc        <= 4'd0;
            bi        <= 2'd0;
            shreg     <= 8'd0;
            par       <= 1'b0;
            b0        <= 8'd0;
            b1        <= 8'd0;
            tcnt      <= 16'd0;
            ps2_mouse <= 25'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= 16'd0;
                if (state == S_IDLE) begin
                    if (!dat_f) begin
                        state <= S_SHIFT;
                        bc    <= 4'd1;
                    end
                end else if (bc <= 4'd8) begin
                    shreg <= {dat_f, shreg[7:1]};
                    bc    <= bc + 4'd1;
                end else if (bc == 4'd9) begin
                    par <= dat_f;
                    bc  <= bc + 4'd1;
                end else begin
                    state <= S_IDLE;
                    bc    <= 4'd0;
                    if ((^{shreg, par}) && dat_f) begin
                        case (bi)
                            2'd0: begin
                                // bit3 of byte0 is always set; anything else is
                                // a mid-packet byte and is dropped to resync.
                                if (shreg[3]) begin
                                    b0 <= shreg;
                                    bi <= 2'd1;
                                end
                            end
                            2'd1: begin
                                b1 <= shreg;
                                bi <= 2'd2;
                            end
                            default: begin
                                ps2_mouse <= {~ps2_mouse[24], shreg, b1, b0};
                                bi        <= 2'd0;
                            end
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                        bi        <= 2'd0;
                    end
                end
            end else if (state == S_SHIFT || bi != 2'd0) begin
                if (tcnt >= TIMEOUT) begin
                    state <= S_IDLE;
                    bc    <= 4'd0;
                    bi    <= 2'd0;
                    tcnt  <= 16'd0;
                end else if (tcnt != 16'hFFFF) begin
                    tcnt <= tcnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb/tb_ps2_mouse_rx.sv - scoreboard bench for ps2_mouse_rx
module tb_ps2_mouse_rx;

    localparam int          FILT    = 4;
    localparam logic [15:0] TIMEOUT = 16'd200;
    localparam int          HALF    = 20;

    logic        clk;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [24:0] ps2_mouse;
    logic        frame_err;

    int          n_assert;
    int          n_fail;
    int          err_cnt;
    logic [24:0] q[$];
    logic [24:0] prev;
    logic        tog;

    ps2_mouse_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_mouse (ps2_mouse),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [24:0] exp_w;
        if (!reset_n) begin
            prev = 25'd0;
        end else begin
            if (frame_err === 1'b1) err_cnt++;
            if (ps2_mouse !== prev) begin
                n_assert++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_update observed=%h expected=no_update", ps2_mouse);
                end
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                    n_assert++;
                    assert (ps2_mouse === exp_w) else begin
                        n_fail++;
                        $error("FAIL packet observed=%h expected=%h", ps2_mouse, exp_w);
                    end
                end
                prev = ps2_mouse;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame; glitch adds a FILT-1 cycle low pulse
    // inside each clock-high phase.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                wait_cyc(8);
                ps2_clk = 1'b0;
                wait_cyc(FILT - 1);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 8 - (FILT - 1));
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bits(b, bad_par, glitch, 11);
    endtask

    task automatic push_pkt(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
        tog = ~tog;
        q.push_back({tog, x2, x1, x0});
    endtask

    task automatic send_pkt(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2, input bit glitch);
        push_pkt(x0, x1, x2);
        send_byte(x0, 1'b0, glitch);
        send_byte(x1, 1'b0, glitch);
        send_byte(x2, 1'b0, glitch);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s pending observed=%0d expected=0", tag, q.size());
        end
    endtask

    task automatic check_err(input string tag, input int exp_n);
        n_assert++;
        assert (err_cnt === exp_n) else begin
            n_fail++;
            $error("FAIL %s frame_err_count observed=%0d expected=%0d", tag, err_cnt, exp_n);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        err_cnt  = 0;
        prev     = 25'd0;
        tog      = 1'b0;
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(2);

        n_assert++;
        assert (ps2_mouse === 25'd0) else begin
            n_fail++;
            $error("FAIL reset_mouse observed=%h expected=%h", ps2_mouse, 25'd0);
        end
        n_assert++;
        assert (frame_err === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_err observed=%b expected=0", frame_err);
        end

        send_pkt(8'h09, 8'h05, 8'hFB, 1'b0);
        drain("pkt1");
        check_err("pkt1", 0);

        send_pkt(8'h28, 8'h00, 8'h80, 1'b0);
        drain("pkt2");

        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        send_pkt(8'h0A, 8'h01, 8'h02, 1'b0);
        drain("bad_parity");
        check_err("bad_parity", 1);

        send_byte(8'h05, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h10, 8'h20, 1'b0);
        drain("resync");
        check_err("resync", 1);

        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        wait_cyc(int'(TIMEOUT) + 10);
        send_pkt(8'h0B, 8'h7F, 8'h81, 1'b0);
        drain("timeout");

        send_pkt(8'h18, 8'h33, 8'h44, 1'b1);
        drain("glitch");

        send_byte(8'h09, 1'b0, 1'b0);
        send_bits(8'h05, 1'b0, 1'b0, 4);
        reset_n = 1'b0;
        #1;
        n_assert++;
        assert (ps2_mouse === 25'd0) else begin
            n_fail++;
            $error("FAIL midreset_mouse observed=%h expected=%h", ps2_mouse, 25'd0);
        end
        n_assert++;
        assert (frame_err === 1'b0) else begin
            n_fail++;
            $error("FAIL midreset_err observed=%b expected=0", frame_err);
        end
        tog     = 1'b0;
        err_cnt = 0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(5);

        send_pkt(8'h09, 8'h01, 8'h02, 1'b0);
        drain("post_reset");
        check_err("final", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
